// File: rtl/reg_file_mp.sv
// Multi-read-port register file with handshaked writes and a post-reset clear sequencer.
// Optional build macro RF_BYPASS_EN selects write-first read bypass; read-first when undefined.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       wr_drop,
  output logic                       init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  clr_idx, clr_idx_nxt;
  logic               init_busy_nxt, wr_ready_nxt, wr_drop_nxt;
  logic               wr_zero_c;
  logic               wr_acc_c;
  logic               mem_we_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [DATA_W-1:0]  mem_din_c;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign wr_zero_c = (ZERO_REG != 0) && (wr_addr == '0);

  // State, sequencer index and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      init_busy <= 1'b1;
      wr_ready  <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_idx   <= clr_idx_nxt;
      init_busy <= init_busy_nxt;
      wr_ready  <= wr_ready_nxt;
      wr_drop   <= wr_drop_nxt;
    end
  end

  // Next state, array write port selection and status next values
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    wr_acc_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = wr_addr;
    mem_din_c   = wr_data;

    case (state)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = clr_idx;
        mem_din_c   = '0;
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = READY;
          clr_idx_nxt = '0;
        end
      end
      READY: begin
        wr_acc_c = wr_en && wr_ready && !wr_zero_c;
        mem_we_c = wr_acc_c;
      end
      default: begin
        state_nxt   = CLEAR;
        clr_idx_nxt = '0;
      end
    endcase

    init_busy_nxt = (state_nxt == CLEAR);
    wr_ready_nxt  = (state_nxt == READY);
    wr_drop_nxt   = wr_en && !wr_ready;
  end

  // Array storage; gated by rst_n so nothing lands while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem[mem_addr_c] <= mem_din_c;
    end
  end

  // Combinational read lanes
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    logic [DATA_W-1:0] lane_k;

    assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      lane_k = mem[addr_k];
`ifdef RF_BYPASS_EN
      if (wr_acc_c && (wr_addr == addr_k)) begin
        lane_k = wr_data;
      end
`endif
      if (init_busy || ((ZERO_REG != 0) && (addr_k == '0))) begin
        lane_k = '0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = lane_k;
  end

endmodule
